// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered full adder.
// master drives operands, slave is the adder.
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             in_valid;
    logic [WIDTH-1:0] S;
    logic             C;
    logic             out_valid;

    modport master (
        output A, B, Cin, in_valid,
        input  S, C, out_valid
    );

    modport slave (
        input  A, B, Cin, in_valid,
        output S, C, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple full adder, 1-cycle latency, valid qualified.
// FULL_ADDER_STATS_EN adds carry_cnt, a saturating count of captured carries.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FULL_ADDER_STATS_EN
    output logic [15:0] carry_cnt,
`endif
    full_adder_if.slave bus
);

    logic [WIDTH-1:0] w_s;
    logic             w_cout;

    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_valid;

    // Carry kept as a process-local variable so the ripple is a plain chain
    always_comb begin
        logic v_c;
        w_s  = '0;
        v_c  = bus.Cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_s[i] = bus.A[i] ^ bus.B[i] ^ v_c;
            v_c    = (bus.A[i] & bus.B[i]) |
                     (bus.A[i] & v_c) |
                     (bus.B[i] & v_c);
        end
        w_cout = v_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s     <= '0;
            r_c     <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s <= w_s;
                r_c <= w_cout;
            end
        end
    end

    assign bus.S         = r_s;
    assign bus.C         = r_c;
    assign bus.out_valid = r_valid;

`ifdef FULL_ADDER_STATS_EN
    logic [15:0] r_carry_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry_cnt <= '0;
        end else if (bus.in_valid && w_cout && r_carry_cnt != 16'hFFFF) begin
            r_carry_cnt <= r_carry_cnt + 16'd1;
        end
    end

    assign carry_cnt = r_carry_cnt;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 and WIDTH=8.
// Results are predicted arithmetically as A+B+Cin.
module tb_full_adder;

    logic clk;
    logic rst;

    full_adder_if #(.WIDTH(1)) if1 ();
    full_adder_if #(.WIDTH(8)) if8 ();

`ifdef FULL_ADDER_STATS_EN
    logic [15:0] cnt1;
    logic [15:0] cnt8;
`endif

    full_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
`ifdef FULL_ADDER_STATS_EN
        .carry_cnt (cnt1),
`endif
        .bus       (if1)
    );

    full_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
`ifdef FULL_ADDER_STATS_EN
        .carry_cnt (cnt8),
`endif
        .bus       (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: last captured result, valid flag, carry count
    logic [7:0]  m1_s, m8_s;
    logic        m1_c, m8_c, m1_v, m8_v;
    int unsigned m1_cnt, m8_cnt;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m1_s = '0; m1_c = 0; m1_v = 0; m1_cnt = 0;
        m8_s = '0; m8_c = 0; m8_v = 0; m8_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".s1"}, 64'(if1.S), 64'(m1_s[0]));
        check({tag, ".c1"}, 64'(if1.C), 64'(m1_c));
        check({tag, ".v1"}, 64'(if1.out_valid), 64'(m1_v));
        check({tag, ".s8"}, 64'(if8.S), 64'(m8_s));
        check({tag, ".c8"}, 64'(if8.C), 64'(m8_c));
        check({tag, ".v8"}, 64'(if8.out_valid), 64'(m8_v));
`ifdef FULL_ADDER_STATS_EN
        check({tag, ".cnt1"}, 64'(cnt1), 64'(m1_cnt));
        check({tag, ".cnt8"}, 64'(cnt8), 64'(m8_cnt));
`endif
    endtask

    // Advance one clock: predict from the operands present at the edge
    task automatic cycle(input string tag);
        int unsigned sum1, sum8;
        logic        v1, v8;
        v1 = if1.in_valid;
        v8 = if8.in_valid;
        sum1 = v1 ? (int'(if1.A) + int'(if1.B) + int'(if1.Cin)) : 0;
        sum8 = v8 ? (int'(if8.A) + int'(if8.B) + int'(if8.Cin)) : 0;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            m1_v = v1;
            m8_v = v8;
            if (v1) begin
                m1_s = 8'(sum1 % 2);
                m1_c = (sum1 >= 2);
                if (m1_c && m1_cnt < 65535) m1_cnt++;
            end
            if (v8) begin
                m8_s = 8'(sum8 % 256);
                m8_c = (sum8 >= 256);
                if (m8_c && m8_cnt < 65535) m8_cnt++;
            end
        end
        check_all(tag);
    endtask

    task automatic drive1(input logic a, input logic b, input logic ci,
                          input logic v);
        if1.A = a; if1.B = b; if1.Cin = ci; if1.in_valid = v;
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic v);
        if8.A = a; if8.B = b; if8.Cin = ci; if8.in_valid = v;
    endtask

    logic [1:0] tt [8];
    logic [7:0] ra, rb;

    initial begin
        tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b01; tt[3] = 2'b10;
        tt[4] = 2'b01; tt[5] = 2'b10; tt[6] = 2'b10; tt[7] = 2'b11;

        rst = 1'b1;
        drive1(0, 0, 0, 0);
        drive8('x, 'x, 1'bx, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Exhaustive 1-bit truth table; dut8 idles with X operands
        for (int i = 0; i < 8; i++) begin
            drive1(i[2], i[1], i[0], 1);
            cycle("tt");
            check($sformatf("tt%0d", i), 64'({if1.C, if1.S}), 64'(tt[i]));
            check($sformatf("tt%0d.v", i), 64'(if1.out_valid), 64'd1);
        end
`ifdef FULL_ADDER_STATS_EN
        check("stats.sweep", 64'(cnt1), 64'd4);
`endif

        // Hold: invalid cycle keeps S/C, drops out_valid
        drive1(1, 0, 0, 1);
        cycle("hold.cap");
        drive1(1, 1, 0, 0);
        cycle("hold.1");
        check("hold.s", 64'(if1.S), 64'd1);
        check("hold.c", 64'(if1.C), 64'd0);
        check("hold.v", 64'(if1.out_valid), 64'd0);
        drive1(1'bx, 1'bx, 1'bx, 0);
        cycle("hold.x");

        // Asynchronous reset between edges
        drive1(1, 1, 1, 1);
        drive8(8'hFF, 8'hFF, 1, 1);
        cycle("ar.cap");
        drive1(0, 0, 0, 0);
        drive8(0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("ar.mid");
        check("ar.v1", 64'(if1.out_valid), 64'd0);
        #1 rst = 1'b0;
        cycle("ar.post0");
        cycle("ar.post1");

        // WIDTH=8 directed boundaries
        drive8(8'hFF, 8'h00, 1, 1);
        cycle("w8.a");
        check("w8.a.cs", 64'({if8.C, if8.S}), 64'h100);
        drive8(8'h5A, 8'hA5, 0, 1);
        cycle("w8.b");
        check("w8.b.cs", 64'({if8.C, if8.S}), 64'h0FF);
        drive8(8'h80, 8'h80, 1, 1);
        cycle("w8.c");
        check("w8.c.cs", 64'({if8.C, if8.S}), 64'h101);
        drive8(8'hFF, 8'hFF, 1, 1);
        cycle("w8.d");
        check("w8.d.cs", 64'({if8.C, if8.S}), 64'h1FF);
        drive8(8'h3C, 8'hC3, 1, 1);
        cycle("w8.e");
        check("w8.e.cs", 64'({if8.C, if8.S}), 64'h100);

        // Back-to-back random, plus random 1-bit traffic with gaps
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            drive8(ra, rb, 1'($urandom), 1);
            drive1(1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom));
            cycle("rnd");
        end
        drive8(0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        cycle("tail");

`ifdef FULL_ADDER_STATS_EN
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("stats.rst", 64'(cnt1), 64'd0);
        check("stats.rst8", 64'(cnt8), 64'd0);
        #1 rst = 1'b0;
        cycle("stats.post");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
